jk_bank_ctrl: RTL and testbench
===============================

// Module: jk_bank_ctrl
// PURPOSE
//  Command sequencer/arbiter for a shared bank of WIDTH negedge-clocked JK flip-flops.
//  Two requesters issue SET/CLR/TOG/LOAD commands; a round-robin arbiter picks one;
//  the controller drives the bank's j/k vectors for exactly one cycle, then waits for settle.
//  Sits between user logic and the JK register bank; sole driver of the bank's j/k inputs.
// PARAMETERS
//  WIDTH      8    number of JK flip-flops in the bank (1..32)
// PORTS
//  clk         in   1      system clock; all controller state updates on posedge
//  rst         in   1      synchronous, active-high reset
//  req0_valid  in   1      requester 0 command valid; held until req0_ack
//  req0_op     in   3      requester 0 opcode
//  req0_mask   in   WIDTH  requester 0 bit mask
//  req0_data   in   WIDTH  requester 0 data (LOAD only)
//  req0_ack    out  1      one-cycle pulse: requester 0 command accepted
//  req1_*      -    -      identical set for requester 1 (valid, op, mask, data, ack)
//  bank_q      in   WIDTH  current q outputs of the JK bank
//  jk_j        out  WIDTH  j inputs to the bank (registered)
//  jk_k        out  WIDTH  k inputs to the bank (registered)
//  busy        out  1      high in DRIVE and SETTLE
//  done        out  1      one-cycle pulse when the bank result is captured
//  grant_id    out  1      requester of the command in flight / last served
//  err_illegal out  1      sticky: an illegal opcode was accepted; cleared by rst only
// BEHAVIOUR
//  Reset (synchronous): state=IDLE; jk_j=jk_k=0; acks=0; busy=0; done=0; grant_id=1
//   (so requester 0 wins the first tie); err_illegal=0. Reset mid-DRIVE drops j/k next cycle.
//  Opcodes -> j/k (computed from latched cmd, loaded at entry to DRIVE):
//   000 NOP : j=0,         k=0
//   001 SET : j=mask,      k=0
//   010 CLR : j=0,         k=mask
//   011 TOG : j=mask,      k=mask
//   100 LOAD: j=data&mask, k=~data&mask
//   101 ROT : see CONFIGURATION; other codes illegal -> NOP, err_illegal set, still acked.
//  FSM:
//   IDLE  : if any valid -> arbitrate, latch winner cmd, pulse winner ack this cycle,
//           grant_id<=winner, -> DRIVE. Else stay, j/k=0.
//   DRIVE : j/k hold computed values for exactly one cycle; bank samples at mid-cycle negedge.
//           -> SETTLE.
//   SETTLE: j/k=0; bank_q stable; at end of cycle pulse done; -> IDLE.
//  Throughput: one command per 3 cycles; ack-to-done latency = 2 cycles.
//  Arbitration: only in IDLE. One valid -> it wins. Both valid -> the requester != grant_id.
//  Requests arriving in DRIVE/SETTLE are not acked; requester keeps valid asserted.
//  A valid dropped before ack is lost (no penalty).
//  j/k are never nonzero outside DRIVE; at most one ack high per cycle.
// CONFIGURATION
//  JK_ROTATE_EN defined: opcode 101 ROT legal: v={bank_q[WIDTH-2:0],bank_q[WIDTH-1]}
//   (rotate left); j=v&mask, k=~v&mask; bank_q is sampled in the IDLE accept cycle.
//   With WIDTH=1, v=bank_q.
//  JK_ROTATE_EN undefined: 101 is illegal (NOP + err_illegal); no bank_q rotate logic.
// TESTING
//  T1 reset: assert rst 2 cycles mid-DRIVE -> jk_j=jk_k=0, busy=0, grant_id=1, err_illegal=0.
//  T2 bank 0x00, req0 SET mask=0xA5 -> ack cycle t, jk_j=0xA5/jk_k=0 in t+1, done at t+2,
//   bank_q=0xA5.
//  T3 bank 0xA5, req1 TOG mask=0x0F -> bank_q=0xAA; then LOAD data=0x3C mask=0xFF
//   -> bank_q=0x3C.
//  T4 req0/req1 both valid continuously with NOP -> acks alternate 0,1,0,1 every 3 cycles.
//  T5 op=110 from req1 -> ack, jk_j=jk_k=0, err_illegal=1 and stays 1 until rst.
//  T6 JK_ROTATE_EN: bank 0x81, ROT mask=0xFF -> bank_q=0x03;
//   without the macro, same stimulus -> bank_q unchanged, err_illegal=1.

Source files
------------

// File: rtl/jk_bank_ctrl_if.sv
// Request/bank bundle between two requesters, jk_bank_ctrl and the negedge JK bank.
// The slave side is the controller; the master side is user logic plus the bank's q outputs.
interface jk_bank_ctrl_if #(parameter int WIDTH = 8);
  logic             req0_valid;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_mask;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ack;
  logic             req1_valid;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_mask;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ack;
  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] jk_j;
  logic [WIDTH-1:0] jk_k;
  logic             busy;
  logic             done;
  logic             grant_id;
  logic             err_illegal;

  modport slave (
    input  req0_valid, req0_op, req0_mask, req0_data,
    input  req1_valid, req1_op, req1_mask, req1_data,
    input  bank_q,
    output req0_ack, req1_ack, jk_j, jk_k, busy, done, grant_id, err_illegal
  );

  modport master (
    output req0_valid, req0_op, req0_mask, req0_data,
    output req1_valid, req1_op, req1_mask, req1_data,
    output bank_q,
    input  req0_ack, req1_ack, jk_j, jk_k, busy, done, grant_id, err_illegal
  );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Round-robin JK bank sequencer: ack in IDLE, j/k driven 1 cycle later, done 2 cycles after ack; requesters hold valid while busy.
// JK_ROTATE_EN makes opcode 101 a legal rotate-left of bank_q, otherwise 101 is illegal.
module jk_bank_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  jk_bank_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SET  = 3'b001;
  localparam logic [2:0] OP_CLR  = 3'b010;
  localparam logic [2:0] OP_TOG  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;

  state_t           r_state;
  state_t           w_next;
  logic             r_grant_id;
  logic             r_err;
  logic [WIDTH-1:0] r_jk_j;
  logic [WIDTH-1:0] r_jk_k;

  logic             w_win;
  logic             w_accept;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_illegal;
  logic             w_ack0;
  logic             w_ack1;
  logic             w_busy;
  logic             w_done;

  // Tie goes to the requester that was not served last.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      w_win = ~r_grant_id;
    end else begin
      w_win = bus.req1_valid;
    end
  end

  assign w_accept = (r_state == S_IDLE) && (bus.req0_valid || bus.req1_valid) && !rst;
  assign w_op     = w_win ? bus.req1_op   : bus.req0_op;
  assign w_mask   = w_win ? bus.req1_mask : bus.req0_mask;
  assign w_data   = w_win ? bus.req1_data : bus.req0_data;

`ifdef JK_ROTATE_EN
  localparam logic [2:0] OP_ROT = 3'b101;
  logic [WIDTH-1:0] w_rot;

  generate
    if (WIDTH == 1) begin : g_rot1
      assign w_rot = bus.bank_q;
    end else begin : g_rotn
      assign w_rot = {bus.bank_q[WIDTH-2:0], bus.bank_q[WIDTH-1]};
    end
  endgenerate
`endif

  always_comb begin
    w_j       = '0;
    w_k       = '0;
    w_illegal = 1'b0;
    case (w_op)
      OP_NOP: begin
        w_j = '0;
        w_k = '0;
      end
      OP_SET:  w_j = w_mask;
      OP_CLR:  w_k = w_mask;
      OP_TOG: begin
        w_j = w_mask;
        w_k = w_mask;
      end
      OP_LOAD: begin
        w_j = w_data & w_mask;
        w_k = ~w_data & w_mask;
      end
`ifdef JK_ROTATE_EN
      OP_ROT: begin
        w_j = w_rot & w_mask;
        w_k = ~w_rot & w_mask;
      end
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_ack0 = 1'b0;
    w_ack1 = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_DRIVE;
          w_ack0 = ~w_win;
          w_ack1 = w_win;
        end
      end
      S_DRIVE: begin
        w_busy = 1'b1;
        w_next = S_SETTLE;
      end
      S_SETTLE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // j/k load only on accept, so they are nonzero in DRIVE alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_jk_j     <= '0;
      r_jk_k     <= '0;
      r_grant_id <= 1'b1;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_jk_j     <= w_j;
      r_jk_k     <= w_k;
      r_grant_id <= w_win;
      if (w_illegal) begin
        r_err <= 1'b1;
      end
    end else begin
      r_jk_j <= '0;
      r_jk_k <= '0;
    end
  end

  assign bus.req0_ack    = w_ack0;
  assign bus.req1_ack    = w_ack1;
  assign bus.jk_j        = r_jk_j;
  assign bus.jk_k        = r_jk_k;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.grant_id    = r_grant_id;
  assign bus.err_illegal = r_err;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: directed vector table, hand sequences, and a randomized run against a transaction-level model.
module tb_jk_bank_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jk_bank_ctrl_if #(.WIDTH(W)) bus ();
  jk_bank_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Negedge JK bank: q+ = j&~q | ~k&q, with a preload path for test setup.
  logic [W-1:0] bank;
  logic [W-1:0] preload_val;
  logic         preload_req;
  assign bus.bank_q = bank;
  always @(negedge clk) begin
    if (preload_req) bank <= preload_val;
    else             bank <= (bus.jk_j & ~bank) | (~bus.jk_k & bank);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bank(input logic [W-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    @(negedge clk);
    #1;
    preload_req = 1'b0;
  endtask

  task automatic drive(input bit who, input logic v, input logic [2:0] op,
                       input logic [W-1:0] mask, input logic [W-1:0] data);
    if (who) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_mask = mask; bus.req1_data = data;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_mask = mask; bus.req0_data = data;
    end
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] q);
    return (q << 1) | (q >> (W - 1));
  endfunction

  // Result-level model: what the bank should end up holding, plus the j/k the table prescribes.
  task automatic ref_cmd(input logic [2:0] op, input logic [W-1:0] mask, input logic [W-1:0] data,
                         input logic [W-1:0] q, output logic [W-1:0] nq, output logic [W-1:0] j,
                         output logic [W-1:0] k, output bit ill);
    nq = q; j = '0; k = '0; ill = 1'b0;
    case (op)
      3'd0: ;
      3'd1: begin nq = q | mask;  j = mask; end
      3'd2: begin nq = q & ~mask; k = mask; end
      3'd3: begin nq = q ^ mask;  j = mask; k = mask; end
      3'd4: begin nq = (q & ~mask) | (data & mask); j = data & mask; k = ~data & mask; end
`ifdef JK_ROTATE_EN
      3'd5: begin nq = (q & ~mask) | (rotl(q) & mask); j = rotl(q) & mask; k = ~rotl(q) & mask; end
`endif
      default: ill = 1'b1;
    endcase
  endtask

  typedef struct {
    bit           who;
    logic [2:0]   op;
    logic [W-1:0] mask;
    logic [W-1:0] data;
    logic [W-1:0] init;
    logic [W-1:0] exp_bank;
    logic [W-1:0] exp_j;
    logic [W-1:0] exp_k;
    logic         exp_err;
  } vec_t;

  typedef struct {
    logic         v;
    logic [2:0]   op;
    logic [W-1:0] mask;
    logic [W-1:0] data;
  } cmd_t;

  localparam int NV = 10;
  vec_t tbl[NV];
  cmd_t rq[2];

  initial begin
    bit rot_en;
`ifdef JK_ROTATE_EN
    rot_en = 1'b1;
`else
    rot_en = 1'b0;
`endif
    tbl[0] = '{1'b0, 3'd1, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 3'd3, 8'h0F, 8'h00, 8'hA5, 8'hAA, 8'h0F, 8'h0F, 1'b0};
    tbl[2] = '{1'b0, 3'd4, 8'hFF, 8'h3C, 8'hAA, 8'h3C, 8'h3C, 8'hC3, 1'b0};
    tbl[3] = '{1'b1, 3'd2, 8'hF0, 8'h00, 8'h3C, 8'h0C, 8'h00, 8'hF0, 1'b0};
    tbl[4] = '{1'b0, 3'd0, 8'hFF, 8'hFF, 8'h5A, 8'h5A, 8'h00, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 3'd4, 8'h0F, 8'hA5, 8'hF0, 8'hF5, 8'h05, 8'h0A, 1'b0};
    if (rot_en) begin
      tbl[6] = '{1'b0, 3'd5, 8'hFF, 8'h00, 8'h81, 8'h03, 8'h03, 8'hFC, 1'b0};
      tbl[7] = '{1'b1, 3'd5, 8'h0F, 8'h00, 8'h81, 8'h83, 8'h03, 8'h0C, 1'b0};
    end else begin
      tbl[6] = '{1'b0, 3'd5, 8'hFF, 8'h00, 8'h81, 8'h81, 8'h00, 8'h00, 1'b1};
      tbl[7] = '{1'b1, 3'd5, 8'h0F, 8'h00, 8'h81, 8'h81, 8'h00, 8'h00, 1'b1};
    end
    tbl[8] = '{1'b1, 3'd6, 8'hFF, 8'h00, 8'h3C, 8'h3C, 8'h00, 8'h00, 1'b1};
    tbl[9] = '{1'b0, 3'd7, 8'h0F, 8'hFF, 8'h3C, 8'h3C, 8'h00, 8'h00, 1'b1};

    rst = 1'b1;
    preload_req = 1'b0;
    preload_val = '0;
    drive(1'b0, 1'b0, 3'd0, '0, '0);
    drive(1'b1, 1'b0, 3'd0, '0, '0);
    nxt();
    nxt();
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_j", bus.jk_j, 0);
    chk("rst_k", bus.jk_k, 0);
    chk("rst_grant", bus.grant_id, 1);
    chk("rst_err", bus.err_illegal, 0);
    chk("rst_ack0", bus.req0_ack, 0);
    chk("rst_ack1", bus.req1_ack, 0);
    nxt();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      set_bank(tbl[i].init);
      nxt();
      drive(tbl[i].who, 1'b1, tbl[i].op, tbl[i].mask, tbl[i].data);
      #2;
      chk($sformatf("v%0d_ack_win", i), tbl[i].who ? bus.req1_ack : bus.req0_ack, 1);
      chk($sformatf("v%0d_ack_lose", i), tbl[i].who ? bus.req0_ack : bus.req1_ack, 0);
      nxt();
      drive(tbl[i].who, 1'b0, 3'd0, '0, '0);
      #2;
      chk($sformatf("v%0d_j", i), bus.jk_j, tbl[i].exp_j);
      chk($sformatf("v%0d_k", i), bus.jk_k, tbl[i].exp_k);
      chk($sformatf("v%0d_busy", i), bus.busy, 1);
      chk($sformatf("v%0d_done_early", i), bus.done, 0);
      nxt();
      #2;
      chk($sformatf("v%0d_done", i), bus.done, 1);
      chk($sformatf("v%0d_bank", i), bank, tbl[i].exp_bank);
      chk($sformatf("v%0d_grant", i), bus.grant_id, tbl[i].who);
      chk($sformatf("v%0d_err", i), bus.err_illegal, tbl[i].exp_err);
    end

    // Reset held for two cycles starting in DRIVE; err_illegal is set going in.
    set_bank(8'h00);
    nxt();
    drive(1'b0, 1'b1, 3'd1, 8'hFF, 8'h00);
    #2;
    chk("t1_ack0", bus.req0_ack, 1);
    nxt();
    drive(1'b0, 1'b0, 3'd0, '0, '0);
    #2;
    chk("t1_drive_j", bus.jk_j, 8'hFF);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      nxt();
      #2;
      chk("t1_j", bus.jk_j, 0);
      chk("t1_k", bus.jk_k, 0);
      chk("t1_busy", bus.busy, 0);
      chk("t1_grant", bus.grant_id, 1);
      chk("t1_err", bus.err_illegal, 0);
    end
    nxt();
    rst = 1'b0;

    // Both requesters saturate with NOPs: service alternates starting with requester 0.
    drive(1'b0, 1'b1, 3'd0, 8'hFF, 8'h00);
    drive(1'b1, 1'b1, 3'd0, 8'hFF, 8'h00);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) nxt();
      #2;
      chk($sformatf("t4_ack0_c%0d", c), bus.req0_ack, (c % 6) == 0);
      chk($sformatf("t4_ack1_c%0d", c), bus.req1_ack, (c % 6) == 3);
    end
    nxt();
    drive(1'b0, 1'b0, 3'd0, '0, '0);
    drive(1'b1, 1'b0, 3'd0, '0, '0);

    // Randomized run against the transaction model.
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
    set_bank(W'($urandom));
    begin
      int           last_acc;
      logic         m_grant;
      logic         m_err;
      logic [W-1:0] m_bank;
      logic [W-1:0] m_j;
      logic [W-1:0] m_k;
      logic [W-1:0] nq;
      logic [W-1:0] tj;
      logic [W-1:0] tk;
      bit           ill;
      bit           win;
      bit           idle;
      int           age;
      last_acc = -100;
      m_grant  = 1'b1;
      m_err    = 1'b0;
      m_bank   = '0;
      m_j      = '0;
      m_k      = '0;
      rq[0] = '{1'b0, 3'd0, '0, '0};
      rq[1] = '{1'b0, 3'd0, '0, '0};
      for (int n = 0; n < 600; n++) begin
        nxt();
        for (int r = 0; r < 2; r++) begin
          if (!rq[r].v) begin
            if ($urandom_range(0, 2) == 0)
              rq[r] = '{1'b1, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom)};
          end else if ($urandom_range(0, 19) == 0) begin
            rq[r].v = 1'b0;
          end
          drive(r[0], rq[r].v, rq[r].op, rq[r].mask, rq[r].data);
        end
        #2;
        age  = n - last_acc;
        idle = (age >= 3);
        win  = (rq[0].v && rq[1].v) ? !m_grant : rq[1].v;
        chk("rnd_ack0", bus.req0_ack, idle && rq[0].v && !win);
        chk("rnd_ack1", bus.req1_ack, idle && rq[1].v && win);
        chk("rnd_busy", bus.busy, (age == 1) || (age == 2));
        chk("rnd_done", bus.done, age == 2);
        chk("rnd_j", bus.jk_j, (age == 1) ? m_j : '0);
        chk("rnd_k", bus.jk_k, (age == 1) ? m_k : '0);
        chk("rnd_grant", bus.grant_id, m_grant);
        chk("rnd_err", bus.err_illegal, m_err);
        if (age == 2) chk("rnd_bank", bank, m_bank);
        if (idle && (rq[0].v || rq[1].v)) begin
          ref_cmd(rq[win].op, rq[win].mask, rq[win].data, bank, nq, tj, tk, ill);
          m_bank   = nq;
          m_j      = tj;
          m_k      = tk;
          m_err    = m_err | ill;
          m_grant  = win;
          last_acc = n;
          rq[win].v = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
